brick_collision_scanner: RTL

- Initiator and reader on the brick-memory port. On each ball-position update it walks every brick record and tests the ball box against each active brick.
- Clears the first hit brick by pulsing the memory write-enable at that index.
- Reports the hit index and the number of bricks still active to the game-control FSM. It sits between the ball-motion logic and the brick memory.

---
 rtl/brick_pkg.sv | 25 ++
 rtl/brick_hit_test.sv | 40 ++++
 rtl/brick_collision_scanner.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/brick_pkg.sv
// Shared brick-record layout and scanner state encoding.
// Combinational definitions only; no latency, no flow control.
package brick_pkg;

    localparam int COORD_W = 8;
    localparam int SIZE_W  = 4;

    // Memory word order is {x, y, w, h, active}, 25 bits.
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [SIZE_W-1:0]  w;
        logic [SIZE_W-1:0]  h;
        logic               active;
    } brick_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CHECK,
        CLEAR,
        DONE
    } scan_state_t;

endpackage

// File: rtl/brick_hit_test.sv
// Axis-aligned box overlap between a square ball and a brick; purely combinational.
// Edges that only touch do not count; widened to 9 bits so sums never wrap.
module brick_hit_test
    import brick_pkg::*;
#(
    parameter int BALL_SIZE = 4
) (
    input  logic [COORD_W-1:0] ball_x_i,
    input  logic [COORD_W-1:0] ball_y_i,
    input  logic [COORD_W-1:0] brick_x_i,
    input  logic [COORD_W-1:0] brick_y_i,
    input  logic [SIZE_W-1:0]  brick_w_i,
    input  logic [SIZE_W-1:0]  brick_h_i,
    output logic               overlap_o
);

    localparam logic [COORD_W:0] BALL_EXT = BALL_SIZE[COORD_W:0];

    logic [COORD_W:0] ball_l;
    logic [COORD_W:0] ball_r;
    logic [COORD_W:0] ball_t;
    logic [COORD_W:0] ball_b;
    logic [COORD_W:0] brick_l;
    logic [COORD_W:0] brick_r;
    logic [COORD_W:0] brick_t;
    logic [COORD_W:0] brick_b;

    assign ball_l  = {1'b0, ball_x_i};
    assign ball_t  = {1'b0, ball_y_i};
    assign ball_r  = ball_l + BALL_EXT;
    assign ball_b  = ball_t + BALL_EXT;
    assign brick_l = {1'b0, brick_x_i};
    assign brick_t = {1'b0, brick_y_i};
    assign brick_r = brick_l + {{(COORD_W+1-SIZE_W){1'b0}}, brick_w_i};
    assign brick_b = brick_t + {{(COORD_W+1-SIZE_W){1'b0}}, brick_h_i};

    assign overlap_o = (ball_r > brick_l) && (ball_l < brick_r) &&
                       (ball_b > brick_t) && (ball_t < brick_b);

endmodule

// File: rtl/brick_collision_scanner.sv
// Walks every brick record per ball update, clears the first active overlapping brick.
// done lands 2*NUM_BRICKS+1 edges after start (+1 with a hit); starts while busy are dropped.
module brick_collision_scanner
    import brick_pkg::*;
#(
    parameter int NUM_BRICKS = 40,
    parameter int INDEX_W    = 6,
    parameter int BALL_SIZE  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [COORD_W-1:0] ball_x,
    input  logic [COORD_W-1:0] ball_y,
    output logic [INDEX_W-1:0] mem_index,
    output logic               mem_we,
    input  logic [COORD_W-1:0] mem_x,
    input  logic [COORD_W-1:0] mem_y,
    input  logic [SIZE_W-1:0]  mem_w,
    input  logic [SIZE_W-1:0]  mem_h,
    input  logic               mem_active,
    output logic               busy,
    output logic               done,
    output logic               hit,
    output logic [INDEX_W-1:0] hit_index,
    output logic [INDEX_W:0]   active_count
);

    localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(NUM_BRICKS - 1);

    scan_state_t        state_q;
    logic [INDEX_W-1:0] idx_q;
    logic [COORD_W-1:0] bx_q;
    logic [COORD_W-1:0] by_q;
    logic               hit_flag_q;
    logic [INDEX_W-1:0] hit_idx_q;
    logic [INDEX_W:0]   count_q;
    logic [INDEX_W-1:0] mem_index_q;
    logic               mem_we_q;
    logic               busy_q;
    logic               done_q;
    logic               hit_q;
    logic [INDEX_W-1:0] hit_index_q;
    logic [INDEX_W:0]   active_count_q;

    brick_t             rec;
    logic               overlap;
    logic               hit_now_d;
    logic               last_d;
    logic [INDEX_W-1:0] idx_d;

    assign rec = '{x: mem_x, y: mem_y, w: mem_w, h: mem_h, active: mem_active};

    brick_hit_test #(
        .BALL_SIZE (BALL_SIZE)
    ) u_hit_test (
        .ball_x_i  (bx_q),
        .ball_y_i  (by_q),
        .brick_x_i (rec.x),
        .brick_y_i (rec.y),
        .brick_w_i (rec.w),
        .brick_h_i (rec.h),
        .overlap_o (overlap)
    );

    assign hit_now_d = rec.active && overlap && !hit_flag_q;
    assign last_d    = (idx_q == LAST_IDX);
    assign idx_d     = idx_q + 1'b1;

    // Memory-facing outputs are loaded on entry to the state that owns them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            bx_q           <= '0;
            by_q           <= '0;
            hit_flag_q     <= 1'b0;
            hit_idx_q      <= '0;
            count_q        <= '0;
            mem_index_q    <= '0;
            mem_we_q       <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            hit_q          <= 1'b0;
            hit_index_q    <= '0;
            active_count_q <= '0;
        end else begin
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    // busy_q is still high during the done pulse; that cycle is not idle.
                    if (start && !busy_q) begin
                        bx_q        <= ball_x;
                        by_q        <= ball_y;
                        idx_q       <= '0;
                        hit_flag_q  <= 1'b0;
                        hit_idx_q   <= '0;
                        count_q     <= '0;
                        mem_index_q <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= ISSUE;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ISSUE: begin
                    state_q <= CHECK;
                end
                CHECK: begin
                    if (hit_now_d) begin
                        hit_idx_q <= idx_q;
                        mem_we_q  <= 1'b1;
                        state_q   <= CLEAR;
                    end else begin
                        if (rec.active) begin
                            count_q <= count_q + 1'b1;
                        end
                        if (last_d) begin
                            state_q <= DONE;
                        end else begin
                            idx_q       <= idx_d;
                            mem_index_q <= idx_d;
                            state_q     <= ISSUE;
                        end
                    end
                end
                CLEAR: begin
                    hit_flag_q <= 1'b1;
                    if (last_d) begin
                        state_q <= DONE;
                    end else begin
                        idx_q       <= idx_d;
                        mem_index_q <= idx_d;
                        state_q     <= ISSUE;
                    end
                end
                DONE: begin
                    done_q         <= 1'b1;
                    hit_q          <= hit_flag_q;
                    hit_index_q    <= hit_idx_q;
                    active_count_q <= count_q;
                    state_q        <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_index    = mem_index_q;
    assign mem_we       = mem_we_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign hit          = hit_q;
    assign hit_index    = hit_index_q;
    assign active_count = active_count_q;

endmodule
